mem_bus_arbiter: RTL and testbench

Shares one SRAM-like memory bus between the pipeline's instruction-fetch port (F stage, `pcF`/`instrF`) and data port (M stage, byte-strobed loads and stores). It serialises transactions through a grant FSM and gives data accesses priority. It returns read data and completion pulses to each port, and generates per-port stall requests for the hazard unit. An instruction fetch cancelled by an exception or branch flush still completes on the bus, but its result is discarded.

---
 rtl/mem_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like bus between the fetch port and the
// data port. One transaction at a time, data has strict priority. A fetch
// cancelled while in flight still finishes on the bus, but its result is
// dropped.
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32  // must stay 32: the byte strobes are 4 bits wide
) (
  input  logic          clk,
  input  logic          rst,

  // Fetch port
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  input  logic          inst_cancel,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_ok,

  // Data port
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_wen,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_ok,

  // Stall requests for the hazard unit
  output logic          stall_inst,
  output logic          stall_data,

  // Memory bus master side
  output logic          bus_req,
  output logic          bus_wr,
  output logic [3:0]    bus_wen,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for a request to grant
    S_ADDR = 2'd1,  // address phase, bus_req high
    S_WAIT = 2'd2,  // address accepted, waiting for data
    S_DONE = 2'd3   // one-cycle completion, ok pulse visible
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  state_e          state_q,      state_d;
  owner_e          owner_q,      owner_d;
  logic            kill_q,       kill_d;
  logic            bus_req_q,    bus_req_d;
  logic            bus_wr_q,     bus_wr_d;
  logic [3:0]      bus_wen_q,    bus_wen_d;
  logic [AW-1:0]   bus_addr_q,   bus_addr_d;
  logic [DW-1:0]   bus_wdata_q,  bus_wdata_d;
  logic            inst_ok_q,    inst_ok_d;
  logic            data_ok_q,    data_ok_d;
  logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DW-1:0]   data_rdata_q, data_rdata_d;

  logic            complete;
  logic            cancel_hit;

  // Next-state, payload latch, completion and discard logic
  always_comb begin
    // NOTE: every variable gets its default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    kill_d       = kill_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_wen_d    = bus_wen_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    complete     = 1'b0;

    // A cancel only matters once the fetch owns the bus; in IDLE it merely
    // blocks the fetch grant below.
    cancel_hit = inst_cancel && (owner_q == OWN_INST) && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          owner_d     = OWN_DATA;
          bus_req_d   = 1'b1;
          bus_wr_d    = data_wr;
          bus_wen_d   = data_wr ? data_wen : 4'b0000;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          state_d     = S_ADDR;
        end else if (inst_req && !inst_cancel) begin
          owner_d     = OWN_INST;
          bus_req_d   = 1'b1;
          bus_wr_d    = 1'b0;
          bus_wen_d   = 4'b0000;
          bus_addr_d  = inst_addr;
          bus_wdata_d = '0;
          state_d     = S_ADDR;
        end
      end

      S_ADDR: begin
        if (bus_addr_ok) begin
          bus_req_d = 1'b0;
          if (bus_data_ok) begin
            complete = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (bus_data_ok) begin
          complete = 1'b1;
        end
      end

      S_DONE: begin
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // DONE clears the discard flag, so a cancel there does not carry over
    // into the next fetch.
    if (cancel_hit && (state_q != S_DONE)) begin
      kill_d = 1'b1;
    end

    // The ok pulse and read data are registered on the way into DONE. A
    // cancel arriving in the completing cycle itself is folded in directly,
    // so the fetch result is dropped even though kill_q is not yet set.
    if (complete) begin
      state_d = S_DONE;
      if (owner_q == OWN_DATA) begin
        data_ok_d = 1'b1;
        if (!bus_wr_q) begin
          data_rdata_d = bus_rdata;
        end
      end else if (!(kill_q || inst_cancel)) begin
        inst_ok_d    = 1'b1;
        inst_rdata_d = bus_rdata;
      end
    end
  end

  // Grant FSM and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      kill_q       <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_wen_q    <= 4'b0000;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      owner_q      <= owner_d;
      kill_q       <= kill_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_wen_q    <= bus_wen_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_wen    = bus_wen_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_ok    = inst_ok_q;
  assign data_ok    = data_ok_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  // Stalls are combinational so the hazard unit sees them in the same cycle
  assign stall_inst = inst_req & ~inst_ok_q;
  assign stall_data = data_req & ~data_ok_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed tests for mem_bus_arbiter. A transaction-level
// model (expected bus transactions in order, a configurable-latency slave and
// the per-port read-data state) is checked against the DUT every cycle, and
// each directed test also pins latencies and values with literal checks.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_cancel;
  logic [DW-1:0] inst_rdata;
  logic          inst_ok;
  logic          data_req;
  logic          data_wr;
  logic [3:0]    data_wen;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_ok;
  logic          stall_inst;
  logic          stall_data;
  logic          bus_req;
  logic          bus_wr;
  logic [3:0]    bus_wen;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_cancel (inst_cancel),
    .inst_rdata  (inst_rdata),
    .inst_ok     (inst_ok),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_wen    (data_wen),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_ok     (data_ok),
    .stall_inst  (stall_inst),
    .stall_data  (stall_data),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_wen     (bus_wen),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    bit          is_data;
    bit          wr;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;  // what the slave returns on the data phase
  } txn_t;

  function automatic txn_t mk(input bit is_data, input bit wr, input logic [3:0] wen,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata);
    txn_t t;
    t.is_data = is_data;
    t.wr      = wr;
    t.wen     = wen;
    t.addr    = addr;
    t.wdata   = wdata;
    t.rdata   = rdata;
    return t;
  endfunction

  txn_t        exp_q[$];
  txn_t        cur;
  bit          in_flight, addr_acc, in_data, done_next, cur_kill, spurious_en;
  int          acnt, dcnt;
  int          addr_delay = 0;
  int          data_delay = 0;
  int          breq_cycles, inst_ok_count;
  logic [31:0] mdl_inst_rdata, mdl_data_rdata;

  task automatic check_payload();
    check("bus_addr", bus_addr, cur.addr);
    check("bus_wr", 32'(bus_wr), 32'(cur.wr));
    check("bus_wen", 32'(bus_wen), 32'(cur.wen));
    if (cur.wr) check("bus_wdata", bus_wdata, cur.wdata);
  endtask

  // Compare process plus slave: checks what the DUT shows this cycle, then
  // decides the slave's responses for the coming edge.
  always @(negedge clk) begin
    bit exp_dok;
    bit exp_iok;
    if (rst) begin
      exp_q.delete();
      in_flight      = 0;
      addr_acc       = 0;
      in_data        = 0;
      done_next      = 0;
      cur_kill       = 0;
      acnt           = 0;
      dcnt           = 0;
      mdl_inst_rdata = '0;
      mdl_data_rdata = '0;
      bus_addr_ok    = 1'b0;
      bus_data_ok    = 1'b0;
      bus_rdata      = '0;
    end else begin
      // Completion: the cycle after the slave's data phase is the ok cycle.
      exp_dok = done_next && cur.is_data;
      exp_iok = done_next && !cur.is_data && !cur_kill;
      if (done_next) begin
        if (cur.is_data && !cur.wr) mdl_data_rdata = cur.rdata;
        if (exp_iok) mdl_inst_rdata = cur.rdata;
        in_flight = 0;
        done_next = 0;
        cur_kill  = 0;
      end
      if (inst_ok) inst_ok_count++;
      check("data_ok", 32'(data_ok), 32'(exp_dok));
      check("inst_ok", 32'(inst_ok), 32'(exp_iok));
      check("data_rdata", data_rdata, mdl_data_rdata);
      check("inst_rdata", inst_rdata, mdl_inst_rdata);
      check("stall_data", 32'(stall_data), 32'(data_req && !data_ok));
      check("stall_inst", 32'(stall_inst), 32'(inst_req && !inst_ok));

      // Address phase: a new transaction must be the next expected one.
      if (bus_req) breq_cycles++;
      if (in_flight) begin
        check("bus_req_phase", 32'(bus_req), 32'(!addr_acc));
        if (bus_req) check_payload();
      end else if (bus_req) begin
        if (exp_q.size() == 0) begin
          check("bus_req_unexpected", 32'(bus_req), 32'd0);
        end else begin
          cur       = exp_q.pop_front();
          in_flight = 1;
          addr_acc  = 0;
          acnt      = 0;
          cur_kill  = 0;
          check_payload();
        end
      end

      if (inst_cancel && in_flight && !cur.is_data) cur_kill = 1;

      // Slave responses for the coming edge
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;
      if (in_flight && !addr_acc && bus_req) begin
        if (acnt == addr_delay) begin
          bus_addr_ok = 1'b1;
          addr_acc    = 1;
          if (data_delay == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = cur.rdata;
            done_next   = 1;
          end else begin
            in_data = 1;
            dcnt    = 1;
          end
        end else begin
          acnt++;
        end
      end else if (in_data) begin
        if (dcnt == data_delay) begin
          bus_data_ok = 1'b1;
          bus_rdata   = cur.rdata;
          done_next   = 1;
          in_data     = 0;
        end else begin
          dcnt++;
        end
      end else if (spurious_en && !in_flight) begin
        bus_data_ok = 1'b1;  // stray data phase while idle: must be ignored
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold requests until their ok, dropping each the cycle after its pulse.
  task automatic wait_done(input bit want_d, input bit want_i, input int budget,
                           output int t_d, output int t_i);
    bit got_d;
    bit got_i;
    int n;
    got_d = !want_d;
    got_i = !want_i;
    n     = 0;
    t_d   = -1;
    t_i   = -1;
    while (!(got_d && got_i) && n < budget) begin
      @(negedge clk);
      if (want_d && data_ok && !got_d) begin got_d = 1; t_d = cyc; end
      if (want_i && inst_ok && !got_i) begin got_i = 1; t_i = cyc; end
      next_cycle();
      n++;
      if (got_d) data_req = 1'b0;
      if (got_i) inst_req = 1'b0;
    end
    check("ok_within_budget", 32'(got_d && got_i), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t_d;
    int t_i;
    rst         = 1'b1;
    inst_req    = 1'b0;
    inst_addr   = '0;
    inst_cancel = 1'b0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wen    = 4'b0000;
    data_addr   = '0;
    data_wdata  = '0;
    spurious_en = 0;
    repeat (2) next_cycle();

    // Reset state
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_data_ok", 32'(data_ok), 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'd0);
    rst = 1'b0;
    repeat (2) next_cycle();

    // Zero-wait load
    exp_q.push_back(mk(1, 0, 4'b0000, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF));
    data_req = 1'b1; data_wr = 1'b0; data_wen = 4'b1111;
    data_addr = 32'h0000_0010; data_wdata = 32'h5555_5555;
    t0 = cyc; breq_cycles = 0;
    wait_done(1, 0, 20, t_d, t_i);
    check("load_ok_latency", 32'(t_d - t0), 32'd2);
    check("load_bus_req_cycles", 32'(breq_cycles), 32'd1);
    @(negedge clk);
    check("load_rdata_literal", data_rdata, 32'hDEAD_BEEF);
    check("load_stall_after_ok", 32'(stall_data), 32'd0);
    next_cycle();

    // Contention: store and fetch together, store goes first
    exp_q.push_back(mk(1, 1, 4'b0011, 32'h2000_0040, 32'h1234_1234, 32'hFFFF_FFFF));
    exp_q.push_back(mk(0, 0, 4'b0000, 32'hBFC0_0000, 32'h0, 32'h3C08_0001));
    data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0011;
    data_addr = 32'h2000_0040; data_wdata = 32'h1234_1234;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    t0 = cyc;
    wait_done(1, 1, 30, t_d, t_i);
    check("contention_data_latency", 32'(t_d - t0), 32'd2);
    check("contention_gap_ge3", 32'((t_i - t_d) >= 3), 32'd1);
    check("contention_inst_latency", 32'(t_i - t0), 32'd5);
    check("store_keeps_data_rdata", data_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Wait states: address accepted after 2 stall cycles, data 3 later
    addr_delay = 2; data_delay = 3;
    exp_q.push_back(mk(1, 0, 4'b0000, 32'h0000_0100, 32'h0, 32'hCAFE_F00D));
    data_req = 1'b1; data_wr = 1'b0; data_wen = 4'b0000;
    data_addr = 32'h0000_0100;
    t0 = cyc; breq_cycles = 0; inst_ok_count = 0;
    wait_done(1, 0, 30, t_d, t_i);
    check("wait_ok_latency", 32'(t_d - t0), 32'd7);
    check("wait_bus_req_cycles", 32'(breq_cycles), 32'd3);
    check("wait_rdata_literal", data_rdata, 32'hCAFE_F00D);

    // Stray bus_data_ok while idle must not disturb anything
    spurious_en = 1;
    repeat (4) next_cycle();
    spurious_en = 0;
    next_cycle();
    check("spurious_data_rdata", data_rdata, 32'hCAFE_F00D);
    check("spurious_inst_rdata", inst_rdata, 32'h3C08_0001);

    // Cancel a fetch while it waits for data
    addr_delay = 0; data_delay = 3;
    exp_q.push_back(mk(0, 0, 4'b0000, 32'hBFC0_0004, 32'h0, 32'h1111_2222));
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    inst_ok_count = 0;
    next_cycle();                         // ADDR, address accepted
    next_cycle();                         // WAIT
    inst_cancel = 1'b1; inst_req = 1'b0;
    next_cycle();
    inst_cancel = 1'b0;
    repeat (6) next_cycle();
    check("cancel_no_inst_ok", 32'(inst_ok_count), 32'd0);
    check("cancel_rdata_kept", inst_rdata, 32'h3C08_0001);

    // Next fetch after the cancel is granted normally
    data_delay = 0;
    exp_q.push_back(mk(0, 0, 4'b0000, 32'hBFC0_0008, 32'h0, 32'h2402_0005));
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    t0 = cyc;
    wait_done(0, 1, 20, t_d, t_i);
    check("after_cancel_latency", 32'(t_i - t0), 32'd2);
    check("after_cancel_rdata", inst_rdata, 32'h2402_0005);
    next_cycle();

    // Asynchronous reset in the middle of an address phase
    addr_delay = 5;
    exp_q.push_back(mk(1, 0, 4'b0000, 32'h0000_0030, 32'h0, 32'h9999_9999));
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0030;
    next_cycle();                         // ADDR, bus_req high
    #2;
    rst = 1'b1;
    #1;
    check("arst_bus_req", 32'(bus_req), 32'd0);
    check("arst_bus_addr", bus_addr, 32'd0);
    check("arst_bus_wr_wen", 32'({bus_wr, bus_wen}), 32'd0);
    check("arst_data_rdata", data_rdata, 32'd0);
    check("arst_inst_rdata", inst_rdata, 32'd0);
    check("arst_oks", 32'({inst_ok, data_ok}), 32'd0);
    data_req = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;
    addr_delay = 0;
    next_cycle();

    // After reset the FSM is idle: a fresh load completes at minimum latency
    exp_q.push_back(mk(1, 0, 4'b0000, 32'h0000_0044, 32'h0, 32'h0BAD_F00D));
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0044;
    t0 = cyc;
    wait_done(1, 0, 20, t_d, t_i);
    check("post_reset_latency", 32'(t_d - t0), 32'd2);
    check("post_reset_rdata", data_rdata, 32'h0BAD_F00D);
    repeat (3) next_cycle();
    check("all_txns_seen", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
